// File: rtl/input_cond_pkg.sv
// Shared defaults and sizing helpers for the input conditioner and its channels.
package input_cond_pkg;

   localparam int DEF_STABLE_TICKS = 4;
   localparam int DEF_REPEAT_DELAY = 32;
   localparam int DEF_REPEAT_RATE  = 8;

   // Width of a counter holding 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-FF synchroniser, stable-tick counter, registered edge pulses.
module debounce_channel
   import input_cond_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int                 CNT_W    = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             raw_p0;
   logic             raw_p1;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The last differing tick of a run both accepts the new level and fires the pulse.
   assign accept = tick && (raw_p1 != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_p0 <= 1'b0;
         raw_p1 <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         // p0 -> p1: synchroniser stages
         raw_p0 <= raw;
         raw_p1 <= raw_p0;
         // p1 -> accepted level and pulses
         rise   <= accept && raw_p1;
         fall   <= accept && !raw_p1;
         if (tick) begin
            if (raw_p1 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level <= raw_p1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Debounces N_BTN buttons and N_SW switches on clk, strobed by a synchronised debounce_clk;
// adds press/release/auto-repeat pulses for buttons and a change pulse for the switch bank.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int N_BTN        = 2,
   parameter int N_SW         = 8,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter bit SW_REVERSE   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             debounce_clk,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic [N_SW-1:0]  sw_level,
   output logic             sw_changed
);

   logic            dclk_p0;
   logic            dclk_p1;
   logic            dclk_p2;
   logic            tick;
   logic [N_SW-1:0] sw_acc;
   logic [N_SW-1:0] sw_rise;
   logic [N_SW-1:0] sw_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dclk_p0 <= 1'b0;
         dclk_p1 <= 1'b0;
         dclk_p2 <= 1'b0;
      end else begin
         // p0 -> p1: synchroniser, p2: edge-detect history
         dclk_p0 <= debounce_clk;
         dclk_p1 <= dclk_p0;
         dclk_p2 <= dclk_p1;
      end
   end

   assign tick = dclk_p1 && !dclk_p2;

   for (genvar i = 0; i < N_BTN; i++) begin : gen_btn
      debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_chan (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .rise  (btn_press[i]),
         .fall  (btn_release[i])
      );
   end

   for (genvar i = 0; i < N_SW; i++) begin : gen_sw
      localparam int OUT_IDX = SW_REVERSE ? (N_SW - 1 - i) : i;
      debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_chan (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .raw   (sw_raw[i]),
         .level (sw_acc[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
      assign sw_level[OUT_IDX] = sw_acc[i];
   end

   // Pulses are registered inside the channels, so this lines up with sw_level.
   assign sw_changed = |(sw_rise | sw_fall);

   if (REPEAT_DELAY > 0) begin : gen_repeat
      localparam int                HOLD_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                              : REPEAT_RATE;
      localparam int                HOLD_W     = cnt_width(HOLD_MAX);
      localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

      logic tick_p3;

      // p3: tick delayed so the hold counters see levels already updated by it
      always_ff @(posedge clk or posedge reset) begin
         if (reset) tick_p3 <= 1'b0;
         else       tick_p3 <= tick;
      end

      for (genvar b = 0; b < N_BTN; b++) begin : gen_rep_btn
         logic [HOLD_W-1:0] hold;
         logic              repeating;
         logic              rep_q;

         // After the first pulse the counter restarts from zero and uses the rate threshold.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hold      <= '0;
               repeating <= 1'b0;
               rep_q     <= 1'b0;
            end else if (!btn_level[b] || btn_press[b]) begin
               hold      <= '0;
               repeating <= 1'b0;
               rep_q     <= 1'b0;
            end else if (tick_p3) begin
               if (hold == (repeating ? RATE_LAST : DELAY_LAST)) begin
                  rep_q     <= 1'b1;
                  hold      <= '0;
                  repeating <= 1'b1;
               end else begin
                  rep_q <= 1'b0;
                  hold  <= hold + 1'b1;
               end
            end else begin
               rep_q <= 1'b0;
            end
         end

         assign btn_repeat[b] = rep_q;
      end
   end else begin : gen_no_repeat
      assign btn_repeat = '0;
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus against a tick-level model.
module tb_input_conditioner;

   localparam int NB = 2;
   localparam int NS = 8;
   localparam int NC = NB + NS;
   localparam int ST = 4;
   localparam int RD = 32;
   localparam int RR = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          debounce_clk = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic [NS-1:0] sw_raw = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
   logic [NS-1:0] sw_level;
   logic          sw_changed;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_conditioner #(
      .N_BTN(NB), .N_SW(NS), .STABLE_TICKS(ST),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SW_REVERSE(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .debounce_clk(debounce_clk),
      .btn_raw(btn_raw), .sw_raw(sw_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .btn_repeat(btn_repeat), .sw_level(sw_level), .sw_changed(sw_changed)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: channel bit c<NB is button c, else switch c-NB.
   logic [3:0]    dh;
   logic [NC-1:0] rh [3];
   logic [NC-1:0] acc, m_rise, m_fall, smp;
   logic [NB-1:0] m_rep;
   logic [NS-1:0] exp_sw;
   int            cnt [NC];
   int            held [NB];
   logic          tick_prev, tk;

   int t_press0 = 0, t_press1 = 0, t_rel0 = 0, t_rep0 = 0, t_rep1 = 0, t_chg = 0, t_any = 0;

   always @(posedge clk) begin
      if (reset) begin
         dh = '0; acc = '0; m_rise = '0; m_fall = '0; m_rep = '0; tick_prev = 1'b0;
         for (int k = 0; k < 3; k++) rh[k] = '0;
         for (int c = 0; c < NC; c++) cnt[c] = 0;
         for (int b = 0; b < NB; b++) held[b] = 0;
      end else begin
         // Repeat decisions use the button state visible before this edge.
         for (int b = 0; b < NB; b++) begin
            if (!acc[b] || m_rise[b]) begin
               held[b] = 0;
               m_rep[b] = 1'b0;
            end else if (tick_prev) begin
               held[b]++;
               m_rep[b] = (held[b] >= RD) && (((held[b] - RD) % RR) == 0);
            end else begin
               m_rep[b] = 1'b0;
            end
         end
         dh = {dh[2:0], debounce_clk};
         rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = {sw_raw, btn_raw};
         tk = dh[2] && !dh[3];
         smp = rh[2];
         m_rise = '0; m_fall = '0;
         if (tk) begin
            for (int c = 0; c < NC; c++) begin
               if (smp[c] != acc[c]) begin
                  cnt[c]++;
                  if (cnt[c] == ST) begin
                     acc[c] = smp[c];
                     cnt[c] = 0;
                     if (smp[c]) m_rise[c] = 1'b1;
                     else        m_fall[c] = 1'b1;
                  end
               end else begin
                  cnt[c] = 0;
               end
            end
         end
         tick_prev = tk;
      end
      for (int i = 0; i < NS; i++) exp_sw[NS-1-i] = acc[NB+i];
      #1;
      chk("btn_level", 32'(btn_level), 32'(acc[NB-1:0]));
      chk("btn_press", 32'(btn_press), 32'(m_rise[NB-1:0]));
      chk("btn_release", 32'(btn_release), 32'(m_fall[NB-1:0]));
      chk("btn_repeat", 32'(btn_repeat), 32'(m_rep));
      chk("sw_level", 32'(sw_level), 32'(exp_sw));
      chk("sw_changed", 32'(sw_changed), 32'(|(m_rise[NC-1:NB] | m_fall[NC-1:NB])));
      t_press0 += int'(btn_press[0]);
      t_press1 += int'(btn_press[1]);
      t_rel0   += int'(btn_release[0]);
      t_rep0   += int'(btn_repeat[0]);
      t_rep1   += int'(btn_repeat[1]);
      t_chg    += int'(sw_changed);
      t_any    += int'(|{btn_press, btn_release, btn_repeat, sw_changed});
   end

   task automatic do_tick(input int n);
      for (int k = 0; k < n; k++) begin
         debounce_clk = 1'b1;
         repeat (3) @(negedge clk);
         debounce_clk = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic rand_tick(input int flip_div);
      int hi, lo, idx;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(1, 4);
      debounce_clk = 1'b1;
      for (int c = 0; c < hi + lo; c++) begin
         if (c == hi) debounce_clk = 1'b0;
         if ($urandom_range(0, flip_div - 1) == 0) begin
            idx = $urandom_range(0, NB - 1);
            btn_raw[idx] = ~btn_raw[idx];
         end
         if ($urandom_range(0, flip_div - 1) == 0) begin
            idx = $urandom_range(0, NS - 1);
            sw_raw[idx] = ~sw_raw[idx];
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed});
   endfunction

   int s0, s1;

   initial begin
      // Reset with random pins
      btn_raw = NB'($urandom);
      sw_raw  = NS'($urandom);
      repeat (5) @(negedge clk);
      chk("reset_outputs", all_outs(), 32'h0);
      reset = 1'b0;
      btn_raw = '0;
      sw_raw = '0;
      @(negedge clk);
      chk("post_reset_outputs", all_outs(), 32'h0);
      do_tick(6);

      // Glitch shorter than STABLE_TICKS on button 1
      s0 = t_press1;
      btn_raw[1] = 1'b1;
      do_tick(3);
      btn_raw[1] = 1'b0;
      do_tick(5);
      chk("glitch_level1", 32'(btn_level[1]), 32'h0);
      chk("glitch_press1", 32'(t_press1 - s0), 32'h0);

      // Bounce on button 0 between ticks, then stable high
      s0 = t_press0;
      btn_raw[0] = 1'b1; @(negedge clk);
      btn_raw[0] = 1'b0; @(negedge clk);
      btn_raw[0] = 1'b1; @(negedge clk);
      chk("bounce_no_pulse", 32'(t_press0 - s0), 32'h0);
      do_tick(5);
      chk("bounce_press0", 32'(t_press0 - s0), 32'h1);
      chk("bounce_level0", 32'(btn_level[0]), 32'h1);

      // Hold: one tick already counted since press; first repeat on the 32nd
      s0 = t_rep0;
      do_tick(30);
      chk("repeat_before_delay", 32'(t_rep0 - s0), 32'h0);
      do_tick(1);
      chk("repeat_first", 32'(t_rep0 - s0), 32'h1);
      do_tick(28);
      chk("repeat_total", 32'(t_rep0 - s0), 32'h4);
      s0 = t_rep0;
      s1 = t_rel0;
      btn_raw[0] = 1'b0;
      do_tick(6);
      chk("release_pulse", 32'(t_rel0 - s1), 32'h1);
      chk("no_repeat_after_release", 32'(t_rep0 - s0), 32'h0);

      // Switch ordering and single change pulse
      s0 = t_chg;
      sw_raw = 8'h01;
      do_tick(5);
      chk("sw_reverse", 32'(sw_level), 32'h80);
      chk("sw_changed_once", 32'(t_chg - s0), 32'h1);
      s0 = t_chg;
      sw_raw = 8'hFF;
      do_tick(5);
      chk("sw_all", 32'(sw_level), 32'hFF);
      chk("sw_changed_multi", 32'(t_chg - s0), 32'h1);

      // Reset while button 1 is held and repeating
      s0 = t_rep1;
      btn_raw[1] = 1'b1;
      do_tick(44);
      chk("repeat_btn1", 32'(t_rep1 - s0), 32'h2);
      debounce_clk = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_repeat_reset", all_outs(), 32'h0);
      btn_raw = '0;
      sw_raw = '0;
      debounce_clk = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      s0 = t_any;
      do_tick(8);
      chk("no_stray_pulse", 32'(t_any - s0), 32'h0);
      chk("levels_after_reset", 32'({btn_level, sw_level}), 32'h0);

      // Random stimulus: slow flips, then a bouncy stretch, with one reset in between
      for (int it = 0; it < 260; it++) begin
         if (it == 130) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         rand_tick(it < 200 ? 40 : 4);
      end
      do_tick(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
